// File: rtl/mouse_pkg.sv
// Shared types and defaults for the mouse-pointer sprite overlay path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mouse_pkg;

    localparam int RGB_W         = 12;
    localparam int COORD_W       = 11;
    localparam int SPRITE_ADDR_W = 10;
    localparam int SPRITE_SIZE   = 32;

    localparam logic [RGB_W-1:0] KEY_COLOR_DEF    = 12'hf0f;
    localparam int               BLINK_FRAMES_DEF = 30;

    typedef logic [RGB_W-1:0]   rgb_t;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/mouse_blink_timer.sv
// Frame counter producing the pointer blink phase; counts every frame_start regardless of cursor_en.
// Latency: blink_on changes on the clock edge that samples the wrapping frame_start.
// Backpressure: none; free-running on frame_start pulses.
module mouse_blink_timer #(
    parameter int FRAMES = 30
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_start,
    output logic blink_on
);

    localparam int                CNT_W = $clog2(FRAMES + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAMES - 1);

    logic [CNT_W-1:0] frame_cnt;

    // Count frames within the current phase; flip the phase when the count wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == LAST) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mouse_sprite_reader.sv
// Mouse-pointer overlay: sprite RAM read address, chroma-key test, pointer mix over the pixel stream.
// Latency: fixed 3 clk from x/y/si_rgb to so_rgb/hit; ram_addr_r 1 clk after x/y.
// Backpressure: none; accepts one pixel per clock, never stalls. Optional blink: MOUSE_BLINK_EN.
module mouse_sprite_reader
    import mouse_pkg::*;
#(
    parameter int                    DATA_WIDTH   = RGB_W,
    parameter int                    ADDR_WIDTH   = SPRITE_ADDR_W,
    parameter int                    COORD_WIDTH  = COORD_W,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR    = KEY_COLOR_DEF,
    parameter int                    BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    input  logic [DATA_WIDTH-1:0]  si_rgb,
    input  logic [COORD_WIDTH-1:0] mouse_x,
    input  logic [COORD_WIDTH-1:0] mouse_y,
    input  logic                   cursor_en,
    output logic [ADDR_WIDTH-1:0]  ram_addr_r,
    input  logic [DATA_WIDTH-1:0]  ram_dout,
    output logic [DATA_WIDTH-1:0]  so_rgb,
    output logic                   hit
);

    // Sprite is square: half the address bits index the column, half the row.
    localparam int SIDE_W = ADDR_WIDTH / 2;

    if ((ADDR_WIDTH % 2) != 0 || BLINK_FRAMES < 1) begin : g_bad_cfg
        $error("mouse_sprite_reader: ADDR_WIDTH must be even and BLINK_FRAMES >= 1");
    end

    // Pointer position and visibility, frozen for a whole frame.
    logic [COORD_WIDTH-1:0] pos_x;
    logic [COORD_WIDTH-1:0] pos_y;
    logic                   en_q;
    logic                   vis_next;

`ifdef MOUSE_BLINK_EN
    logic blink_on;

    mouse_blink_timer #(
        .FRAMES      (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .blink_on    (blink_on)
    );

    // Phase is sampled alongside cursor_en so the pointer cannot appear or vanish mid-frame.
    assign vis_next = cursor_en & blink_on;
`else
    assign vis_next = cursor_en;
`endif

    // Offsets from the pointer corner, one extra bit so pixels left/above the pointer go "negative".
    logic [COORD_WIDTH:0] dx;
    logic [COORD_WIDTH:0] dy;
    logic                 in_spr;

    assign dx = {1'b0, x} - {1'b0, pos_x};
    assign dy = {1'b0, y} - {1'b0, pos_y};

    // Inside iff every bit above the texel index is clear: rejects negative and >= sprite side in one
    // test, and never wraps past the screen edge.
    assign in_spr = en_q
                  & (dx[COORD_WIDTH:SIDE_W] == '0)
                  & (dy[COORD_WIDTH:SIDE_W] == '0);

    // Pipeline state.
    logic                  in_d1;
    logic                  in_d2;
    logic [DATA_WIDTH-1:0] rgb_d1;
    logic [DATA_WIDTH-1:0] rgb_d2;
    logic                  opaque;

    assign opaque = in_d2 & (ram_dout != KEY_COLOR);

    // Latch pointer position/visibility at frame start; the pixel sharing that cycle still sees the old values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x <= '0;
            pos_y <= '0;
            en_q  <= 1'b0;
        end else if (frame_start) begin
            pos_x <= mouse_x;
            pos_y <= mouse_y;
            en_q  <= vis_next;
        end
    end

    // Stage 1: issue the texel read and carry region flag and background alongside.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_r <= '0;
            in_d1      <= 1'b0;
            rgb_d1     <= '0;
        end else begin
            ram_addr_r <= {dy[SIDE_W-1:0], dx[SIDE_W-1:0]};
            in_d1      <= in_spr;
            rgb_d1     <= si_rgb;
        end
    end

    // Stage 2: wait out the registered RAM read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_d2  <= 1'b0;
            rgb_d2 <= '0;
        end else begin
            in_d2  <= in_d1;
            rgb_d2 <= rgb_d1;
        end
    end

    // Stage 3: key out transparent texels and mix the pointer over the background.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            so_rgb <= '0;
            hit    <= 1'b0;
        end else begin
            so_rgb <= opaque ? ram_dout : rgb_d2;
            hit    <= opaque;
        end
    end

endmodule
